// File: rtl/ahb_lite_sram_slv_if.sv
`default_nettype none
// ============================================================================
// ahb_lite_sram_slv_if : AHB-Lite bus bundle between a master and the SRAM slave
// Rev 1.0
// ============================================================================
interface ahb_lite_sram_slv_if #(
  parameter int ADDR_W = 32
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic [1:0]        HTRANS;
  logic              HMASTLOCK;
  logic              HREADY;
  logic [31:0]       HWDATA;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    output HREADY, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    input  HREADY, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface
`default_nettype wire

// File: rtl/ahb_lite_sram_slv.sv
`default_nettype none
// ============================================================================
// ahb_lite_sram_slv : AHB-Lite word-organised SRAM slave with ERROR response;
// optional wait states under macro AHB_SRAM_WAIT_EN.            Rev 1.0
// ============================================================================
module ahb_lite_sram_slv #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic          HCLK,
  input  wire logic          HRESETn,
  ahb_lite_sram_slv_if.slave bus
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [ADDR_W:0] c_limit       = (ADDR_W + 1)'(4 * DEPTH);
  localparam logic [3:0]      c_wait_cycles = 4'(WAIT_CYCLES);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_access = 3'd1;
  localparam logic [2:0] c_err1   = 3'd3;
  localparam logic [2:0] c_err2   = 3'd4;
`ifdef AHB_SRAM_WAIT_EN
  localparam logic [2:0] c_wait   = 3'd2;
`endif

  logic [2:0]      state_q, state_d;
  logic [c_aw+1:0] addr_q, addr_d;
  logic            write_q, write_d;
  logic [1:0]      size_q, size_d;
`ifdef AHB_SRAM_WAIT_EN
  logic [3:0]      wcnt_q, wcnt_d;
`endif

  logic [31:0]     mem_q [DEPTH];

  logic            w_accept;
  logic            w_align_ok;
  logic            w_legal;
  logic [3:0]      w_be;
  logic [c_aw-1:0] w_idx;
  logic [31:0]     w_word;
  logic [31:0]     w_merged;
  logic            w_wr;
  logic            w_hreadyout;
  logic            w_hresp;
  logic [31:0]     w_hrdata;

  // New transfers are only taken while the slave itself is ready.
  assign w_accept = bus.HSEL && bus.HREADY && bus.HTRANS[1] &&
                    ((state_q == c_idle) || (state_q == c_access) || (state_q == c_err2));

  always_comb begin
    w_align_ok = 1'b0;
    case (bus.HSIZE)
      3'd0:    w_align_ok = 1'b1;
      3'd1:    w_align_ok = !bus.HADDR[0];
      3'd2:    w_align_ok = (bus.HADDR[1:0] == 2'b00);
      default: w_align_ok = 1'b0;
    endcase
  end

  assign w_legal = w_align_ok && ({1'b0, bus.HADDR} < c_limit);

  // State / data-phase control registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= c_idle;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
`ifdef AHB_SRAM_WAIT_EN
      wcnt_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
`ifdef AHB_SRAM_WAIT_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
`ifdef AHB_SRAM_WAIT_EN
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
`ifdef AHB_SRAM_WAIT_EN
      c_wait: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q <= 4'd1) state_d = c_access;
      end
`endif
      c_err1: state_d = c_err2;
      default: begin
        state_d = c_idle;
        if (w_accept) begin
          addr_d  = bus.HADDR[c_aw+1:0];
          write_d = bus.HWRITE;
          size_d  = bus.HSIZE[1:0];
          if (!w_legal) begin
            state_d = c_err1;
          end else begin
            state_d = c_access;
`ifdef AHB_SRAM_WAIT_EN
            if (c_wait_cycles != 4'd0) begin
              state_d = c_wait;
              wcnt_d  = c_wait_cycles;
            end
`endif
          end
        end
      end
    endcase
  end

  always_comb begin
    w_be = 4'b0000;
    case (size_q)
      2'd0:    w_be[addr_q[1:0]] = 1'b1;
      2'd1:    w_be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  assign w_idx  = addr_q[c_aw+1:2];
  assign w_word = mem_q[w_idx];
  assign w_wr   = (state_q == c_access) && write_q;

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign w_merged[8*b +: 8] = w_be[b] ? bus.HWDATA[8*b +: 8] : w_word[8*b +: 8];
  end

  // Write commits at the edge closing ACCESS, so a back-to-back read sees it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (w_wr) begin
      mem_q[w_idx] <= w_merged;
    end
  end

  always_comb begin
    w_hreadyout = 1'b1;
    w_hresp     = 1'b0;
    w_hrdata    = 32'd0;
    case (state_q)
`ifdef AHB_SRAM_WAIT_EN
      c_wait: w_hreadyout = 1'b0;
`endif
      c_err1: begin
        w_hreadyout = 1'b0;
        w_hresp     = 1'b1;
      end
      c_err2:   w_hresp = 1'b1;
      c_access: if (!write_q) w_hrdata = w_word;
      default: ;
    endcase
  end

  assign bus.HREADYOUT = w_hreadyout;
  assign bus.HRESP     = w_hresp;
  assign bus.HRDATA    = w_hrdata;

`ifdef AHB_SRAM_WAIT_EN
  wire unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};
`else
  wire unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0], c_wait_cycles};
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_sram_slv.sv
`default_nettype none
// ============================================================================
// tb_ahb_lite_sram_slv : scoreboard bench for the AHB-Lite SRAM slave
// Rev 1.0
// ============================================================================
module tb_ahb_lite_sram_slv;

  localparam int ADDR_W      = 32;
  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 2;
  localparam int IW          = $clog2(DEPTH);
`ifdef AHB_SRAM_WAIT_EN
  localparam int EXP_WAITS = WAIT_CYCLES;
`else
  localparam int EXP_WAITS = 0;
`endif

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
    int          waits;
  } exp_t;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slv_if #(.ADDR_W(ADDR_W)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_lite_sram_slv #(
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          total = 0;
  int          bad   = 0;
  bit          mon_en    = 1'b1;
  bit          dp_active = 1'b0;
  int          lowcnt    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the edge that completes the current cycle with HREADY high.
  task automatic step_ready();
    bit rdy;
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      rdy = bus.HREADY;
      @(posedge HCLK);
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("ready_timeout", 32'(rdy), 32'd1);
    #1;
  endtask

  task automatic idle(input int n, input bit sel, input logic [1:0] trans);
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    repeat (n) step_ready();
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [1:0] trans);
    exp_t    e;
    bit      legal;
    bit      lane;
    int      ix;
    legal = (size == 3'd0) || (size == 3'd1 && !addr[0]) ||
            (size == 3'd2 && addr[1:0] == 2'b00);
    legal = legal && (addr < 4 * DEPTH);
    ix    = int'(addr[IW+1:2]);
    e.err   = !legal;
    e.rd    = !wr;
    e.waits = legal ? EXP_WAITS : 1;
    e.data  = 32'd0;
    if (mon_en) begin
      if (legal && !wr) e.data = model[ix];
      if (legal && wr) begin
        for (int b = 0; b < 4; b++) begin
          lane = (size == 3'd2) || (size == 3'd1 && (b / 2) == int'(addr[1])) ||
                 (size == 3'd0 && b == int'(addr[1:0]));
          if (lane) model[ix][8*b +: 8] = wdata[8*b +: 8];
        end
      end
      sb.push_back(e);
    end
    bus.HSEL   = 1'b1;
    bus.HADDR  = addr;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    bus.HTRANS = trans;
    step_ready();
    bus.HWDATA = wdata;
  endtask

  // Data-phase monitor: compares completed beats against the scoreboard.
  always @(negedge HCLK) begin : mon
    exp_t e;
    if (!HRESETn) begin
      dp_active = 1'b0;
    end else if (mon_en) begin
      if (dp_active) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
          dp_active = 1'b0;
        end else if (!bus.HREADYOUT) begin
          lowcnt++;
          chk("wait_resp", 32'(bus.HRESP), 32'(sb[0].err));
          chk("wait_rdata", bus.HRDATA, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("resp", 32'(bus.HRESP), 32'(e.err));
          chk(e.rd ? "rdata" : "wr_rdata", bus.HRDATA, e.data);
          chk("waits", 32'(lowcnt), 32'(e.waits));
          dp_active = 1'b0;
        end
      end else begin
        chk("idle_ready", 32'(bus.HREADYOUT), 32'd1);
        chk("idle_resp", 32'(bus.HRESP), 32'd0);
        chk("idle_rdata", bus.HRDATA, 32'd0);
      end
      if (bus.HSEL && bus.HREADY && bus.HTRANS[1]) begin
        dp_active = 1'b1;
        lowcnt    = 0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HWRITE = 1'b0; bus.HSIZE = 3'd0;
    bus.HBURST = 3'd0; bus.HPROT = 4'd0; bus.HTRANS = 2'b00; bus.HMASTLOCK = 1'b0;
    bus.HWDATA = 32'd0;

    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    idle(2, 1'b0, 2'b00);

    // word write then back-to-back read of the same address
    issue(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 2'b10);
    issue(1'b0, 32'h10, 3'd2, 32'h0, 2'b10);
    idle(2, 1'b1, 2'b01);

    // byte / halfword merge
    issue(1'b1, 32'h0, 3'd2, 32'h11223344, 2'b10);
    issue(1'b1, 32'h2, 3'd0, 32'h00AA0000, 2'b10);
    issue(1'b1, 32'h0, 3'd1, 32'h00005566, 2'b10);
    issue(1'b0, 32'h0, 3'd2, 32'h0, 2'b10);
    idle(1, 1'b0, 2'b00);

    // top-of-range boundary and error responses
    issue(1'b1, 32'h4, 3'd2, 32'h0BADCAFE, 2'b10);
    issue(1'b1, 32'h3FC, 3'd2, 32'hA5A5A5A5, 2'b10);
    issue(1'b1, 32'h3FF, 3'd0, 32'h7E000000, 2'b10);
    issue(1'b0, 32'h3FC, 3'd2, 32'h0, 2'b10);
    issue(1'b0, 32'h400, 3'd2, 32'h0, 2'b10);
    idle(2, 1'b0, 2'b00);
    issue(1'b1, 32'h400, 3'd2, 32'hFFFFFFFF, 2'b10);
    issue(1'b1, 32'h6, 3'd2, 32'hFFFFFFFF, 2'b10);
    issue(1'b1, 32'h4, 3'd3, 32'hFFFFFFFF, 2'b10);
    issue(1'b1, 32'h5, 3'd1, 32'hFFFFFFFF, 2'b10);
    issue(1'b0, 32'h4, 3'd2, 32'h0, 2'b10);
    issue(1'b0, 32'h0, 3'd2, 32'h0, 2'b10);
    idle(1, 1'b0, 2'b00);

    // INCR4 burst: fill then read back
    bus.HBURST = 3'd3;
    for (int i = 0; i < 4; i++)
      issue(1'b1, 32'h20 + 32'(4 * i), 3'd2, 32'hC0DE0000 + 32'(i), (i == 0) ? 2'b10 : 2'b11);
    idle(1, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++)
      issue(1'b0, 32'h20 + 32'(4 * i), 3'd2, 32'h0, (i == 0) ? 2'b10 : 2'b11);
    bus.HBURST = 3'd0;
    idle(1, 1'b0, 2'b00);

    // random mix including illegal sizes and out-of-range addresses
    for (int i = 0; i < 40; i++) begin
      a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(1008, 1039));
      sz = 3'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), a, sz, $urandom, 2'b10);
      if ($urandom_range(0, 3) == 0) idle(1, 1'b0, 2'b00);
    end
    idle(2, 1'b0, 2'b00);

    // asynchronous reset in the middle of a write data phase
    mon_en = 1'b0;
    issue(1'b1, 32'h8, 3'd2, 32'hCAFEF00D, 2'b10);
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    #2;
    HRESETn = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_resp", 32'(bus.HRESP), 32'd0);
    chk("rst_rdata", bus.HRDATA, 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    mon_en  = 1'b1;
    idle(1, 1'b0, 2'b00);
    issue(1'b0, 32'h8, 3'd2, 32'h0, 2'b10);
    issue(1'b0, 32'h10, 3'd2, 32'h0, 2'b10);
    idle(3, 1'b0, 2'b00);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
